// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one external combinational ALU.
// Requesters are served in turn; results come back tagged with their ID.
module alu_share_arbiter #(
  parameter  int NREQ   = 4,
  parameter  int DATA_W = 8,
  localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DATA_W-1:0] req_a,
  input  logic [NREQ*DATA_W-1:0] req_b,
  input  logic [NREQ*3-1:0]      req_op,
  output logic [DATA_W-1:0]      alu_a,
  output logic [DATA_W-1:0]      alu_b,
  output logic [2:0]             alu_sel,
  input  logic [DATA_W-1:0]      alu_y,
  input  logic                   alu_cout,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [DATA_W-1:0]      rsp_y,
  output logic                   rsp_cout,
  output logic                   busy,
  output logic [15:0]            ops_done
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t              state_q, state_d;
  logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic [2:0]          alu_sel_q, alu_sel_d;
  logic [IDW-1:0]      rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]   rsp_y_q, rsp_y_d;
  logic                rsp_cout_q, rsp_cout_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [15:0]         ops_done_q, ops_done_d;

  logic                gnt_found;
  logic [IDW-1:0]      gnt_idx;
  int                  cand;
  logic [IDW-1:0]      cand_idx;
  logic [DATA_W-1:0]   win_a;
  logic [DATA_W-1:0]   win_b;
  logic [2:0]          win_op;

  // Pick the first valid requester after rr_ptr, wrapping around.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand     = (int'(rr_ptr_q) + k) % NREQ;
      cand_idx = cand[IDW-1:0];
      if (!gnt_found && req_valid[cand_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
  end

  // Select the winning requester's operand bundle.
  always_comb begin
    win_a  = '0;
    win_b  = '0;
    win_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        win_a  = req_a[i*DATA_W +: DATA_W];
        win_b  = req_b[i*DATA_W +: DATA_W];
        win_op = req_op[i*3 +: 3];
      end
    end
  end

  assign req_ready = (state_q == IDLE && gnt_found)
                   ? (NREQ'(1) << gnt_idx) : '0;

  // Next-state and register updates for IDLE -> EXEC -> RESP.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    rsp_id_d    = rsp_id_q;
    rsp_y_d     = rsp_y_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_valid_d = rsp_valid_q;
    ops_done_d  = ops_done_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_found) begin
          alu_a_d   = win_a;
          alu_b_d   = win_b;
          alu_sel_d = win_op;
          rsp_id_d  = gnt_idx;
          rr_ptr_d  = gnt_idx;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        rsp_y_d     = alu_y;
        rsp_cout_d  = alu_cout;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (ops_done_q != 16'hFFFF)
            ops_done_d = ops_done_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; ptr resets so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= IDW'(NREQ - 1);
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      rsp_id_q    <= '0;
      rsp_y_q     <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      ops_done_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      rsp_id_q    <= rsp_id_d;
      rsp_y_q     <= rsp_y_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_valid_q <= rsp_valid_d;
      ops_done_q  <= ops_done_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_cout  = rsp_cout_q;
  assign busy      = (state_q != IDLE);
  assign ops_done  = ops_done_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter with a reference ALU attached.
// Directed vector table plus hand-written multi-cycle sequences.
module tb_alu_share_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;

  logic             clk;
  logic             rst_n;
  logic [NREQ-1:0]  req_valid;
  logic [NREQ-1:0]  req_ready;
  logic [NREQ*DW-1:0] req_a;
  logic [NREQ*DW-1:0] req_b;
  logic [NREQ*3-1:0]  req_op;
  logic [DW-1:0]    alu_a;
  logic [DW-1:0]    alu_b;
  logic [2:0]       alu_sel;
  logic [DW-1:0]    alu_y;
  logic             alu_cout;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_id;
  logic [DW-1:0]    rsp_y;
  logic             rsp_cout;
  logic             busy;
  logic [15:0]      ops_done;

  alu_share_arbiter #(.NREQ(NREQ), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_y(alu_y), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_cout(rsp_cout),
    .busy(busy), .ops_done(ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: ADD SUB AND OR XOR NOT INC DEC.
  logic [8:0] t;
  always_comb begin
    t = 9'h0;
    case (alu_sel)
      3'd0: t = {1'b0, alu_a} + {1'b0, alu_b};
      3'd1: t = {1'b0, alu_a} - {1'b0, alu_b};
      3'd2: t = {1'b0, alu_a & alu_b};
      3'd3: t = {1'b0, alu_a | alu_b};
      3'd4: t = {1'b0, alu_a ^ alu_b};
      3'd5: t = {1'b0, ~alu_a};
      3'd6: t = {1'b0, alu_a} + 9'd1;
      3'd7: t = {1'b0, alu_a} - 9'd1;
      default: t = 9'h0;
    endcase
    alu_y    = t[7:0];
    alu_cout = t[8];
  end

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] y;
    logic       cout;
  } vec_t;

  vec_t vt[9];
  int   n_pass;
  int   n_total;
  int   exp_ops;
  int   g_q[$];
  int   r_id_q[$];
  int   r_y_q[$];
  int   r_c_q[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic bump_ops();
    if (exp_ops != 32'hFFFF) exp_ops++;
  endtask

  // One isolated request; starts and ends at a negedge in IDLE.
  task automatic run_one(input vec_t v, input int idx);
    string s;
    s = $sformatf("v%0d", idx);
    req_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*DW +: DW] = 8'hA5;
      req_b[i*DW +: DW] = 8'h5A;
      req_op[i*3 +: 3]  = 3'b011;
    end
    req_a[v.id*DW +: DW] = v.a;
    req_b[v.id*DW +: DW] = v.b;
    req_op[v.id*3 +: 3]  = v.op;
    req_valid[v.id]      = 1'b1;
    #1;
    chk({s, "_ready"}, 32'(req_ready), 32'(1 << v.id));
    @(negedge clk);
    req_valid = '0;
    chk({s, "_exec_busy"}, 32'(busy), 32'd1);
    chk({s, "_exec_rv"}, 32'(rsp_valid), 32'd0);
    chk({s, "_alu_a"}, 32'(alu_a), 32'(v.a));
    chk({s, "_alu_sel"}, 32'(alu_sel), 32'(v.op));
    chk({s, "_exec_rdy"}, 32'(req_ready), 32'd0);
    @(negedge clk);
    chk({s, "_rv"}, 32'(rsp_valid), 32'd1);
    chk({s, "_id"}, 32'(rsp_id), 32'(v.id));
    chk({s, "_y"}, 32'(rsp_y), 32'(v.y));
    chk({s, "_cout"}, 32'(rsp_cout), 32'(v.cout));
    @(negedge clk);
    bump_ops();
    chk({s, "_ops"}, 32'(ops_done), 32'(exp_ops));
    chk({s, "_idle"}, 32'(busy), 32'd0);
  endtask

  // Observe n cycles, logging grants and responses; drops served
  // requests unless keep is set.
  task automatic run_cycles(input int n, input bit keep);
    logic [NREQ-1:0] clr;
    clr = '0;
    g_q.delete();
    r_id_q.delete();
    r_y_q.delete();
    r_c_q.delete();
    for (int c = 0; c < n; c++) begin
      req_valid = req_valid & ~clr;
      clr = '0;
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) begin
          g_q.push_back(i);
          if (!keep) clr[i] = 1'b1;
        end
      end
      if (rsp_valid && rsp_ready) begin
        r_id_q.push_back(int'(rsp_id));
        r_y_q.push_back(int'(rsp_y));
        r_c_q.push_back(c);
      end
      @(negedge clk);
    end
    req_valid = req_valid & ~clr;
  endtask

  initial begin
    int ord[6];
    n_pass  = 0;
    n_total = 0;
    exp_ops = 0;
    vt[0] = '{0, 8'hF0, 8'h20, 3'b000, 8'h10, 1'b1};
    vt[1] = '{1, 8'h0F, 8'h00, 3'b101, 8'hF0, 1'b0};
    vt[2] = '{2, 8'h00, 8'h00, 3'b111, 8'hFF, 1'b1};
    vt[3] = '{3, 8'hFF, 8'h00, 3'b110, 8'h00, 1'b1};
    vt[4] = '{1, 8'h30, 8'h10, 3'b001, 8'h20, 1'b0};
    vt[5] = '{2, 8'h10, 8'h20, 3'b001, 8'hF0, 1'b1};
    vt[6] = '{3, 8'hCC, 8'hAA, 3'b010, 8'h88, 1'b0};
    vt[7] = '{0, 8'hCC, 8'hAA, 3'b011, 8'hEE, 1'b0};
    vt[8] = '{1, 8'hCC, 8'hAA, 3'b100, 8'h66, 1'b0};

    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rv", 32'(rsp_valid), 32'd0);
    chk("rst_ops", 32'(ops_done), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_rsp_y", 32'(rsp_y), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // All requesters valid continuously: strict rotation from 0.
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*DW +: DW] = 8'(i * 16 + 1);
      req_b[i*DW +: DW] = 8'h01;
      req_op[i*3 +: 3]  = 3'b000;
    end
    req_valid = 4'b1111;
    run_cycles(18, 1'b1);
    req_valid = '0;
    ord = '{0, 1, 2, 3, 0, 1};
    chk("rr_ngrant", 32'(g_q.size()), 32'd6);
    chk("rr_nrsp", 32'(r_id_q.size()), 32'd6);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("rr_grant%0d", k),
          (k < g_q.size()) ? g_q[k] : -1, ord[k]);
      chk($sformatf("rr_rspid%0d", k),
          (k < r_id_q.size()) ? r_id_q[k] : -1, ord[k]);
      chk($sformatf("rr_rspy%0d", k),
          (k < r_y_q.size()) ? r_y_q[k] : -1, ord[k] * 16 + 2);
      chk($sformatf("rr_cyc%0d", k),
          (k < r_c_q.size()) ? r_c_q[k] : -1, 2 + 3 * k);
    end
    exp_ops = 6;
    chk("rr_ops", 32'(ops_done), 32'(exp_ops));

    for (int v = 0; v < 9; v++) run_one(vt[v], v);

    // Response back-pressure: fields hold, nobody is granted.
    rsp_ready = 1'b0;
    req_a[1*DW +: DW] = 8'h0F;
    req_op[1*3 +: 3]  = 3'b101;
    req_valid = 4'b0010;
    #1;
    chk("st_ready", 32'(req_ready), 32'b0010);
    @(negedge clk);
    req_valid = 4'b1101;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("st_rv%0d", c), 32'(rsp_valid), 32'd1);
      chk($sformatf("st_id%0d", c), 32'(rsp_id), 32'd1);
      chk($sformatf("st_y%0d", c), 32'(rsp_y), 32'hF0);
      chk($sformatf("st_co%0d", c), 32'(rsp_cout), 32'd0);
      chk($sformatf("st_rdy%0d", c), 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    bump_ops();
    chk("st_idle", 32'(busy), 32'd0);
    chk("st_rv_clr", 32'(rsp_valid), 32'd0);
    chk("st_next", 32'(req_ready), 32'b0100);
    chk("st_ops", 32'(ops_done), 32'(exp_ops));
    req_valid = '0;

    // Reset in EXEC aborts; afterwards 0 is served before 2.
    req_a[0*DW +: DW] = 8'h11;
    req_b[0*DW +: DW] = 8'h22;
    req_op[0*3 +: 3]  = 3'b000;
    req_a[2*DW +: DW] = 8'h40;
    req_b[2*DW +: DW] = 8'h01;
    req_op[2*3 +: 3]  = 3'b001;
    req_valid = 4'b0101;
    @(negedge clk);
    chk("rm_exec", 32'(busy), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rm_busy", 32'(busy), 32'd0);
    chk("rm_alu_a", 32'(alu_a), 32'd0);
    chk("rm_alu_b", 32'(alu_b), 32'd0);
    chk("rm_id", 32'(rsp_id), 32'd0);
    chk("rm_rv", 32'(rsp_valid), 32'd0);
    chk("rm_ops", 32'(ops_done), 32'd0);
    @(negedge clk);
    chk("rm_rv_hold", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    exp_ops = 0;
    run_cycles(8, 1'b0);
    chk("rm_ngrant", 32'(g_q.size()), 32'd2);
    chk("rm_g0", (g_q.size() > 0) ? g_q[0] : -1, 0);
    chk("rm_g1", (g_q.size() > 1) ? g_q[1] : -1, 2);
    chk("rm_nrsp", 32'(r_id_q.size()), 32'd2);
    chk("rm_r0", (r_id_q.size() > 0) ? r_id_q[0] : -1, 0);
    chk("rm_r1", (r_id_q.size() > 1) ? r_id_q[1] : -1, 2);
    chk("rm_y0", (r_y_q.size() > 0) ? r_y_q[0] : -1, 32'h33);
    chk("rm_y1", (r_y_q.size() > 1) ? r_y_q[1] : -1, 32'h3F);
    exp_ops = 2;
    chk("rm_ops2", 32'(ops_done), 32'(exp_ops));

    // Saturation of the completion counter.
    force dut.ops_done_q = 16'hFFFE;
    @(posedge clk);
    #1;
    release dut.ops_done_q;
    @(negedge clk);
    exp_ops = 32'hFFFE;
    chk("sat_pre", 32'(ops_done), 32'hFFFE);
    for (int v = 0; v < 3; v++) run_one(vt[v], 100 + v);
    chk("sat_final", 32'(ops_done), 32'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
